// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and default sizes for the register-file write arbiter.
package reg_write_arbiter_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ     = 4;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester-side handshake plus the register-file write port, bundled for the arbiter.
interface reg_write_arbiter_if
  import reg_write_arbiter_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_lock;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_ready;
  logic                    reg_write;
  logic [ADDR_W-1:0]       reg_addr;
  logic [DATA_W-1:0]       reg_data;
  logic [ID_W-1:0]         grant_id;
  logic                    locked;

  modport master (
    output req_valid, req_lock, req_addr, req_data,
    input  req_ready, reg_write, reg_addr, reg_data, grant_id, locked
  );

  modport slave (
    input  req_valid, req_lock, req_addr, req_data,
    output req_ready, reg_write, reg_addr, reg_data, grant_id, locked
  );

endinterface

// File: rtl/reg_write_arbiter_rr_priority_select.sv
// Combinational rotating-priority picker: first set request at or above start_i, wrapping.
module rr_priority_select
  import reg_write_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  start_i,
  output logic [N_REQ-1:0] grant_o
);

  logic [N_REQ-1:0] ge_mask;
  logic [N_REQ-1:0] masked;
  logic [N_REQ-1:0] pick;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_mask
    assign ge_mask[gi] = (start_i <= ID_W'(gi));
  end

  // Prefer requests at or above the pointer; otherwise wrap to the lowest one.
  assign masked  = req_i & ge_mask;
  assign pick    = (|masked) ? masked : req_i;
  assign grant_o = pick & (~pick + N_REQ'(1));

endmodule

// File: rtl/reg_write_arbiter.sv
// N-requester write arbiter with locked bursts feeding one register-file write port.
// Define REG_ARB_ROUND_ROBIN_EN for rotating priority; otherwise requester 0 always wins.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic              clk,
  input logic              rst_n,
  reg_write_arbiter_if.slave arb_if
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e        state_q;
  logic [ID_W-1:0]   owner_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic              reg_write_q;
  logic [ADDR_W-1:0] reg_addr_q;
  logic [DATA_W-1:0] reg_data_q;
  logic [ID_W-1:0]   grant_id_q;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];
  logic [N_REQ-1:0]  arb_grant;
  logic [N_REQ-1:0]  ready;
  logic              accept;
  logic [ID_W-1:0]   acc_idx;
  logic [ID_W-1:0]   rr_ptr_d;
  logic [CNT_W-1:0]  beat_cnt_d;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = arb_if.req_addr[gi*ADDR_W +: ADDR_W];
    assign data_arr[gi] = arb_if.req_data[gi*DATA_W +: DATA_W];
  end

  rr_priority_select #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_select (
    .req_i   (arb_if.req_valid),
    .start_i (rr_ptr_q),
    .grant_o (arb_grant)
  );

  // Nothing is accepted while reset is asserted, whatever state_q holds.
  always_comb begin
    ready = '0;
    if (rst_n) begin
      if (state_q == LOCKED) begin
        ready[owner_q] = arb_if.req_valid[owner_q];
      end else begin
        ready = arb_grant;
      end
    end
  end

  always_comb begin
    acc_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (ready[k]) begin
        acc_idx = ID_W'(k);
      end
    end
  end

  assign accept     = |ready;
  assign beat_cnt_d = beat_cnt_q + CNT_W'(1);

`ifdef REG_ARB_ROUND_ROBIN_EN
  assign rr_ptr_d = (acc_idx == ID_W'(N_REQ - 1)) ? '0 : acc_idx + ID_W'(1);
`else
  assign rr_ptr_d = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ARB;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      rr_ptr_q    <= '0;
      reg_write_q <= 1'b0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
      grant_id_q  <= '0;
    end else begin
      reg_write_q <= 1'b0;
      if (accept) begin
        // Register 0 is hard-wired, so its beats are consumed without a strobe.
        reg_write_q <= (addr_arr[acc_idx] != '0);
        reg_addr_q  <= addr_arr[acc_idx];
        reg_data_q  <= data_arr[acc_idx];
        grant_id_q  <= acc_idx;
        rr_ptr_q    <= rr_ptr_d;
      end
      case (state_q)
        ARB: begin
          if (accept && arb_if.req_lock[acc_idx]) begin
            state_q    <= LOCKED;
            owner_q    <= acc_idx;
            beat_cnt_q <= CNT_W'(1);
          end
        end
        LOCKED: begin
          if (accept) begin
            beat_cnt_q <= beat_cnt_d;
            if (!arb_if.req_lock[owner_q] || beat_cnt_d == CNT_W'(MAX_BURST)) begin
              state_q <= ARB;
            end
          end else begin
            state_q <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign arb_if.req_ready = ready;
  assign arb_if.reg_write = reg_write_q;
  assign arb_if.reg_addr  = reg_addr_q;
  assign arb_if.reg_data  = reg_data_q;
  assign arb_if.grant_id  = grant_id_q;
  assign arb_if.locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Table-driven bench for reg_write_arbiter: per-row expected grant, with a scoreboard for the t+1 outputs.
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_write_arbiter #(
    .N_REQ(N), .DATA_W(DW), .ADDR_W(AW), .MAX_BURST(MB)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .arb_if (bus)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] valid;
    logic [3:0] lock;
    logic [3:0] zaddr;
    int         exp_acc;
    logic       exp_locked;
  } vec_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    id;
    logic          lk;
  } out_t;

  vec_t vecs[$];
  out_t sb[$];
  int   checks = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l,
                     input logic [3:0] z, input int acc, input logic lk);
    vec_t t;
    t.rst_n = r; t.valid = v; t.lock = l; t.zaddr = z;
    t.exp_acc = acc; t.exp_locked = lk;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] addr_of(input int k, input int i, input logic [3:0] z);
    if (z[i]) return '0;
    return AW'((k + i) % 31 + 1);
  endfunction

  function automatic logic [DW-1:0] data_of(input int k, input int i, input logic [3:0] z);
    if (z[i]) return 32'hDEADBEEF;
    return 32'hC0DE0000 | DW'(k << 4) | DW'(i);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    out_t e, prev, got;
    logic [3:0] er;

    // Reset holds everything idle even with all requests up.
    add(0, 4'b1111, 4'b0000, 4'b0000, -1, 0);
    add(0, 4'b0000, 4'b0000, 4'b0000, -1, 0);
`ifdef REG_ARB_ROUND_ROBIN_EN
    add(1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b0000, 1, 0);
    add(1, 4'b1111, 4'b0000, 4'b0000, 2, 0);
    add(1, 4'b1111, 4'b0000, 4'b0000, 3, 0);
`else
    add(1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b1111, 4'b0000, 4'b0000, 0, 0);
`endif
    add(1, 4'b0000, 4'b1111, 4'b0000, -1, 0);
    // Address 0 beat: accepted, no strobe, data still captured.
    add(1, 4'b0010, 4'b0000, 4'b0010, 1, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, -1, 0);
    // Requester 2 locks for a full MAX_BURST, requester 0 waits.
    add(1, 4'b0100, 4'b0100, 4'b0000, 2, 1);
    add(1, 4'b0101, 4'b0100, 4'b0000, 2, 1);
    add(1, 4'b0101, 4'b0100, 4'b0000, 2, 1);
    add(1, 4'b0101, 4'b0100, 4'b0000, 2, 0);
    add(1, 4'b0101, 4'b0100, 4'b0000, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, -1, 0);
    // Owner 3 drops valid after two beats; requester 1 must wait one cycle.
    add(1, 4'b1000, 4'b1000, 4'b0000, 3, 1);
    add(1, 4'b1010, 4'b1000, 4'b0000, 3, 1);
    add(1, 4'b0010, 4'b1000, 4'b0000, -1, 0);
    add(1, 4'b0010, 4'b0000, 4'b0000, 1, 0);
    // Reset in the middle of requester 1's burst.
    add(1, 4'b0010, 4'b0010, 4'b0000, 1, 1);
    add(1, 4'b0010, 4'b0010, 4'b0000, 1, 1);
    add(0, 4'b0011, 4'b0011, 4'b0000, -1, 0);
    add(1, 4'b0011, 4'b0000, 4'b0000, 0, 0);
`ifdef REG_ARB_ROUND_ROBIN_EN
    add(1, 4'b0011, 4'b0000, 4'b0000, 1, 0);
    add(1, 4'b0011, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0011, 4'b0000, 4'b0000, 1, 0);
    add(1, 4'b0011, 4'b0000, 4'b0000, 0, 0);
`else
    add(1, 4'b0011, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0011, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0011, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0011, 4'b0000, 4'b0000, 0, 0);
`endif
    // Burst ended early by releasing req_lock.
    add(1, 4'b0001, 4'b0001, 4'b0000, 0, 1);
    add(1, 4'b0001, 4'b0000, 4'b0000, 0, 0);
    add(1, 4'b0000, 4'b0000, 4'b0000, -1, 0);

    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    prev = '{wr: 1'b0, addr: '0, data: '0, id: '0, lk: 1'b0};

    @(negedge clk);
    for (int k = 0; k < vecs.size(); k++) begin
      v = vecs[k];
      rst_n = v.rst_n;
      bus.req_valid = v.valid;
      bus.req_lock  = v.lock;
      for (int i = 0; i < N; i++) begin
        bus.req_addr[i*AW +: AW] = addr_of(k, i, v.zaddr);
        bus.req_data[i*DW +: DW] = data_of(k, i, v.zaddr);
      end
      #1;
      er = (v.exp_acc < 0) ? 4'b0000 : 4'(1 << v.exp_acc);
      check("req_ready", k, 64'(bus.req_ready), 64'(er));

      if (!v.rst_n) begin
        e = '{wr: 1'b0, addr: '0, data: '0, id: '0, lk: 1'b0};
      end else if (v.exp_acc >= 0) begin
        e.addr = addr_of(k, v.exp_acc, v.zaddr);
        e.data = data_of(k, v.exp_acc, v.zaddr);
        e.wr   = (e.addr != '0);
        e.id   = 2'(v.exp_acc);
        e.lk   = v.exp_locked;
      end else begin
        e = prev;
        e.wr = 1'b0;
        e.lk = v.exp_locked;
      end
      sb.push_back(e);
      prev = e;

      @(posedge clk);
      #1;
      got = sb.pop_front();
      check("reg_write", k, 64'(bus.reg_write), 64'(got.wr));
      check("reg_addr",  k, 64'(bus.reg_addr),  64'(got.addr));
      check("reg_data",  k, 64'(bus.reg_data),  64'(got.data));
      check("grant_id",  k, 64'(bus.grant_id),  64'(got.id));
      check("locked",    k, 64'(bus.locked),    64'(got.lk));
      $display("row %0d rst_n=%0b valid=%b lock=%b acc=%0d wr=%0b addr=%0h data=%h id=%0d locked=%0b",
               k, v.rst_n, v.valid, v.lock, v.exp_acc, bus.reg_write, bus.reg_addr,
               bus.reg_data, bus.grant_id, bus.locked);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 Parameter DATA_W, default 32: write data width.
REQ-003 Parameter ADDR_W, default 5: register address width.
REQ-004 Parameter MAX_BURST, default 4: maximum beats per locked burst, 2..16.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  N_REQ  per-requester write request.
REQ-008 req_lock  in  N_REQ  per-requester request to keep grant for the next beat.
REQ-009 req_addr  in  N_REQ*ADDR_W  packed target addresses; requester i at slice i.
REQ-010 req_data  in  N_REQ*DATA_W  packed write data; requester i at slice i.
REQ-011 req_ready  out  N_REQ  one-hot or zero; beat accepted when req_valid[i] & req_ready[i].
REQ-012 reg_write  out  1  write strobe to register file port.
REQ-013 reg_addr  out  ADDR_W  write address.
REQ-014 reg_data  out  DATA_W  write data.
REQ-015 grant_id  out  clog2(N_REQ)  index of last accepted requester.
REQ-016 locked  out  1  high while in LOCKED state.

Function
REQ-017 States: ARB, LOCKED.
REQ-018 ARB: req_ready combinational; at most one bit high, selecting the first valid requester scanning upward from rr_ptr with wrap.
REQ-019 rr_ptr updates to (i+1) mod N_REQ on every accept from i; unchanged when no accept.
REQ-020 LOCKED: req_ready[owner] = req_valid[owner]; all other ready bits 0.
REQ-021 ARB -> LOCKED on accept with req_lock[i]=1; owner=i, beat_cnt=1.
REQ-022 LOCKED, owner accept: beat_cnt increments; if req_lock[owner]=0 or beat_cnt+1 = MAX_BURST, return to ARB.
REQ-023 LOCKED, req_valid[owner]=0: return to ARB next cycle, no accept that cycle.
REQ-024 Latency: a beat accepted in cycle t drives reg_write=1, reg_addr, reg_data in cycle t+1 (registered outputs).
REQ-025 Accepted beat with addr 0: accepted normally, reg_write stays 0 at t+1 (register 0 hard-wired); reg_addr/reg_data still update.
REQ-026 No accept in cycle t: reg_write=0 at t+1; reg_addr/reg_data hold.
REQ-027 No valid requests: req_ready all 0; state and rr_ptr unchanged (except REQ-023).
REQ-028 Back-to-back accepts every cycle supported; throughput one beat per cycle.
REQ-029 req_lock ignored on cycles without accept.

Reset
REQ-030 rst_n=0 at rising edge: state=ARB, rr_ptr=0, beat_cnt=0, reg_write=0, reg_addr=0, reg_data=0, grant_id=0, locked=0.
REQ-031 During reset cycle req_ready all 0; beats presented are not accepted.
REQ-032 Reset mid-burst discards lock; first post-reset cycle arbitrates from requester 0.

Configuration
REQ-033 Macro REG_ARB_ROUND_ROBIN_EN defined: rr_ptr rotation per REQ-019.
REQ-034 Macro undefined: fixed priority, requester 0 highest; rr_ptr held at 0; lock behaviour unchanged.

Structure
REQ-035 Shared package holds the state enum (ARB, LOCKED) and default width constants (DATA_W, ADDR_W).
REQ-036 One sub-module, rr_priority_select: N_REQ-wide request vector plus start pointer in, one-hot grant out, combinational.

Verification
REQ-037 Reset then req_valid=4'b1111, no lock, 4 cycles -> accept order 0,1,2,3; reg_write pulses at t+1 each.
REQ-038 req_valid[2]=1, lock=1 for 6 beats, req_valid[0]=1 -> owner 2 gets 4 beats (MAX_BURST), then requester 0 accepted.
REQ-039 req_valid[1] with addr=0, data=32'hDEADBEEF -> req_ready[1]=1, next cycle reg_write=0, reg_data=32'hDEADBEEF.
REQ-040 LOCKED owner 3 drops valid after beat 2 -> next cycle state=ARB, requester 1 accepted.
REQ-041 rst_n=0 mid-burst with owner 1 -> locked=0, reg_write=0; after release requester 0 wins over 1.
REQ-042 Build without REG_ARB_ROUND_ROBIN_EN, req_valid=4'b0011 held -> requester 0 accepted every cycle, requester 1 starved.
